// File: rtl/mux_4to1_if.sv
// Interface bundling the data/select/enable signals of mux_4to1.
//   en        output-register load enable
//   in0..in3  WIDTH-bit data inputs, select codes 0..3
//   s0, s1    select bits, select code = {s0, s1}
//   out       WIDTH-bit selected data
// master: the side that drives data/select (e.g. a testbench or upstream logic).
// slave:  the multiplexer itself.
interface mux_4to1_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] out;

  modport master (
    output en,
    output in0,
    output in1,
    output in2,
    output in3,
    output s0,
    output s1,
    input  out
  );

  modport slave (
    input  en,
    input  in0,
    input  in1,
    input  in2,
    input  in3,
    input  s0,
    input  s1,
    output out
  );
endinterface

// File: rtl/mux_4to1.sv
// 4-input, WIDTH-bit multiplexer with an optional output register.
//   clk    system clock, rising-edge active
//   rst_n  asynchronous, active-low reset (clears the output register)
//   bus    mux_4to1_if slave modport: en, in0..in3, s0, s1 in; out out
// OUT_REG=1: out is registered with load enable en (1-cycle latency).
// OUT_REG=0: out follows the selected input combinationally; clk/rst_n/en unused.
module mux_4to1 #(
  parameter int unsigned WIDTH   = 4,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_4to1_if.slave   bus
);

  logic [WIDTH-1:0] mux_d;

  // Nested ternaries rather than a case with default: an X/Z on a select bit
  // must propagate to the result instead of being silently mapped to an input.
  always_comb begin
    mux_d = bus.s0 ? (bus.s1 ? bus.in3 : bus.in2)
                   : (bus.s1 ? bus.in1 : bus.in0);
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    always_comb begin
      out_d = out_q;
      if (bus.en) begin
        out_d = mux_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    assign bus.out = out_q;
  end else begin : g_comb
    assign bus.out = mux_d;
  end

endmodule

// File: tb/tb_mux_4to1.sv
module tb_mux_4to1;
  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [WIDTH-1:0] exp_q;  // reference model of the registered output

  mux_4to1_if #(.WIDTH(WIDTH)) bus ();

  mux_4to1 #(
    .WIDTH   (WIDTH),
    .OUT_REG (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: out=%b expected=%b at %0t", tag, obs, req, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                       input logic x0, input logic x1);
    bus.en  = e;
    bus.in0 = a;
    bus.in1 = b;
    bus.in2 = c;
    bus.in3 = d;
    bus.s0  = x0;
    bus.s1  = x1;
  endtask

  // Reference: an array of the four inputs indexed by the integer select code.
  task automatic tick();
    logic [WIDTH-1:0] ins [4];
    int idx;
    @(posedge clk);
    ins[0] = bus.in0;
    ins[1] = bus.in1;
    ins[2] = bus.in2;
    ins[3] = bus.in3;
    idx = 2 * int'(bus.s0) + int'(bus.s1);
    if (rst_n && bus.en) exp_q = ins[idx];
    #1;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 check_val("rst_async", bus.out, '0);
    exp_q = '0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_q    = '0;
    rst_n    = 1'b1;
    drive(1'b1, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b1, 1'b1);

    // 1. Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1 check_val("reset_async", bus.out, 4'b0000);
    tick();
    check_val("reset_held", bus.out, 4'b0000);

    // 2. Select 00
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b0001, 4'b0000, 4'b0011, 4'b0111, 1'b0, 1'b0);
    tick();
    check_val("sel00", bus.out, 4'b0001);

    // 3. Walk select codes; also confirm the one-cycle latency
    @(negedge clk);
    bus.s1 = 1'b1;
    #1 check_val("latency", bus.out, 4'b0001);
    tick();
    check_val("sel01", bus.out, 4'b0000);
    @(negedge clk);
    bus.s0 = 1'b1; bus.s1 = 1'b0;
    tick();
    check_val("sel10", bus.out, 4'b0011);
    @(negedge clk);
    bus.s1 = 1'b1;
    tick();
    check_val("sel11", bus.out, 4'b0111);

    // 4. Hold with en=0
    @(negedge clk);
    bus.en = 1'b0; bus.s0 = 1'b0; bus.s1 = 1'b0;
    tick();
    check_val("hold_a", bus.out, 4'b0111);
    tick();
    check_val("hold_b", bus.out, 4'b0111);
    @(negedge clk);
    bus.en = 1'b1;
    tick();
    check_val("reenable", bus.out, 4'b0001);

    // 5. Unselected inputs ignored
    @(negedge clk);
    bus.s0 = 1'b1; bus.s1 = 1'b0;
    tick();
    check_val("sel10_again", bus.out, 4'b0011);
    @(negedge clk);
    bus.in0 = 4'b1110; bus.in1 = 4'b1111; bus.in3 = 4'b0101;
    tick();
    check_val("unsel_toggle", bus.out, 4'b0011);
    @(negedge clk);
    bus.in2 = 4'b1010;
    tick();
    check_val("sel_in2_chg", bus.out, 4'b1010);

    // 6. Mid-run reset between edges
    @(negedge clk);
    reset_pulse();
    #1 check_val("rst_released", bus.out, 4'b0000);
    tick();
    check_val("reload", bus.out, 4'b1010);

    // Randomized traffic against the reference model
    exp_q = bus.out === 4'b1010 ? 4'b1010 : 4'b1010;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
            WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 15) == 0) reset_pulse();
      tick();
      check_val("random", bus.out, exp_q);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
